// File: rtl/ex_stage_md_if.sv
// Bundle between the ID/EX register and the execute stage. The slave modport is
// the stage's view; the master modport drives the stage.
interface ex_stage_md_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid_i, in_ready_o, flush_i;
  logic [DATA_WIDTH-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [1:0]            fwd_a_i, fwd_b_i;
  logic [DATA_WIDTH-1:0] mem_fwd_data_i, wb_fwd_data_i;
  logic                  sel_a_i, sel_b_i;
  logic [3:0]            alu_op_i;
  logic                  md_req_i;
  logic [2:0]            md_op_i;
  logic [REG_ADDR_W-1:0] rd_add_i;
  logic                  regwrite_i, mem_rd_i, mem_wr_i;
  logic [3:0]            mem_op_i;
  logic [1:0]            sel_to_reg_i;

  logic                  out_valid_o;
  logic [DATA_WIDTH-1:0] result_o, store_data_o, pc_o, pc_dest_o;
  logic                  zero_o;
  logic [REG_ADDR_W-1:0] rd_add_o;
  logic                  regwrite_o, mem_rd_o, mem_wr_o;
  logic [3:0]            mem_op_o;
  logic [1:0]            sel_to_reg_o;

  modport slave (
    input  in_valid_i, flush_i, pc_i, rs1_data_i, rs2_data_i, imm_i, fwd_a_i, fwd_b_i,
           mem_fwd_data_i, wb_fwd_data_i, sel_a_i, sel_b_i, alu_op_i, md_req_i, md_op_i,
           rd_add_i, regwrite_i, mem_rd_i, mem_wr_i, mem_op_i, sel_to_reg_i,
    output in_ready_o, out_valid_o, result_o, store_data_o, pc_o, pc_dest_o, zero_o,
           rd_add_o, regwrite_o, mem_rd_o, mem_wr_o, mem_op_o, sel_to_reg_o
  );

  modport master (
    output in_valid_i, flush_i, pc_i, rs1_data_i, rs2_data_i, imm_i, fwd_a_i, fwd_b_i,
           mem_fwd_data_i, wb_fwd_data_i, sel_a_i, sel_b_i, alu_op_i, md_req_i, md_op_i,
           rd_add_i, regwrite_i, mem_rd_i, mem_wr_i, mem_op_i, sel_to_reg_i,
    input  in_ready_o, out_valid_o, result_o, store_data_o, pc_o, pc_dest_o, zero_o,
           rd_add_o, regwrite_o, mem_rd_o, mem_wr_o, mem_op_o, sel_to_reg_o
  );
endinterface

// File: rtl/ex_stage_md.sv
// Execute stage: forwarding, ALU, branch target and EX/MEM register. Defining
// EX_MD_EN adds the iterative shift-add multiply / restoring divide unit.
module ex_stage_md #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  ex_stage_md_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int SH = $clog2(DATA_WIDTH);

  logic [W-1:0]          fwd_a, fwd_b, op_a, op_b, alu_res, pc_dest;
  logic [REG_ADDR_W-1:0] rd_add;
  logic                  in_ready, accept, alu_load;

  function automatic logic [W-1:0] fwd_sel(input logic [1:0] s, input logic [W-1:0] rf,
                                           input logic [W-1:0] mem, input logic [W-1:0] wb);
    case (s)
      2'b01:   fwd_sel = mem;
      2'b10:   fwd_sel = wb;
      default: fwd_sel = rf;
    endcase
  endfunction

  function automatic logic [W-1:0] alu(input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic [SH-1:0]       sh;
    sa = a;
    sh = b[SH-1:0];
    case (op)
      4'd0:    alu = a + b;
      4'd1:    alu = a - b;
      4'd2:    alu = a << sh;
      4'd3:    alu = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd4:    alu = {{(W-1){1'b0}}, (a < b)};
      4'd5:    alu = a ^ b;
      4'd6:    alu = a >> sh;
      4'd7:    alu = sa >>> sh;
      4'd8:    alu = a | b;
      4'd9:    alu = a & b;
      4'd10:   alu = b;
      default: alu = '0;
    endcase
  endfunction

  assign fwd_a   = fwd_sel(bus.fwd_a_i, bus.rs1_data_i, bus.mem_fwd_data_i, bus.wb_fwd_data_i);
  assign fwd_b   = fwd_sel(bus.fwd_b_i, bus.rs2_data_i, bus.mem_fwd_data_i, bus.wb_fwd_data_i);
  assign op_a    = bus.sel_a_i ? bus.pc_i  : fwd_a;
  assign op_b    = bus.sel_b_i ? bus.imm_i : fwd_b;
  assign alu_res = alu(bus.alu_op_i, op_a, op_b);
  assign pc_dest = bus.pc_i + bus.imm_i;
  assign rd_add  = bus.rd_add_i;
  assign accept  = bus.in_valid_i & in_ready & ~bus.flush_i;
  assign bus.in_ready_o = in_ready;

`ifdef EX_MD_EN
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  logic [0:0]            state_q;
  logic [SH-1:0]         cnt_q;
  logic                  md_accept, md_done;
  logic                  a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
  logic [W-1:0]          a_mag, b_mag, spec_res, md_res;
  logic [2:0]            md_op_p1;
  logic                  neg_p1, spec_p1;
  logic [W-1:0]          hi_p1, lo_p1, opb_p1, spec_res_p1;
  logic [W-1:0]          store_p1, pc_p1, pcd_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic [8:0]            ctrl_p1;
  logic [W:0]            mul_sum, div_trial;
  logic [W-1:0]          mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
  logic [2*W-1:0]        prod_s;

  assign in_ready  = (state_q == IDLE);
  assign md_accept = accept & bus.md_req_i;
  assign alu_load  = accept & ~bus.md_req_i;

  // Accept-time operand conditioning: magnitudes, result sign and special divides
  assign a_sgn    = (bus.md_op_i == 3'd1) | (bus.md_op_i == 3'd2) |
                    (bus.md_op_i == 3'd4) | (bus.md_op_i == 3'd6);
  assign b_sgn    = (bus.md_op_i == 3'd1) | (bus.md_op_i == 3'd4) | (bus.md_op_i == 3'd6);
  assign a_neg    = a_sgn & op_a[W-1];
  assign b_neg    = b_sgn & op_b[W-1];
  assign a_mag    = a_neg ? -op_a : op_a;
  assign b_mag    = b_neg ? -op_b : op_b;
  assign div0     = bus.md_op_i[2] & (op_b == '0);
  assign ovf      = bus.md_op_i[2] & ~bus.md_op_i[0] & (op_a == MIN) & (&op_b);
  assign spec_res = div0 ? (bus.md_op_i[1] ? op_a : '1) : (bus.md_op_i[1] ? '0 : MIN);

  // One iteration: hi/lo hold {partial product, multiplier} or {remainder, dividend}
  assign mul_sum   = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, opb_p1} : '0);
  assign mul_hi_n  = mul_sum[W:1];
  assign mul_lo_n  = {mul_sum[0], lo_p1[W-1:1]};
  assign div_trial = {hi_p1, lo_p1[W-1]} - {1'b0, opb_p1};
  assign div_hi_n  = div_trial[W] ? {hi_p1[W-2:0], lo_p1[W-1]} : div_trial[W-1:0];
  assign div_lo_n  = {lo_p1[W-2:0], ~div_trial[W]};
  assign prod_s    = neg_p1 ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
  assign md_done   = (state_q == BUSY) & ~bus.flush_i & (spec_p1 | (cnt_q == SH'(W-1)));

  always_comb begin
    if (spec_p1)           md_res = spec_res_p1;
    else if (!md_op_p1[2]) md_res = (md_op_p1[1:0] == 2'd0) ? prod_s[W-1:0] : prod_s[2*W-1:W];
    else if (md_op_p1[1])  md_res = neg_p1 ? -div_hi_n : div_hi_n;
    else                   md_res = neg_p1 ? -div_lo_n : div_lo_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (bus.flush_i) begin
      state_q <= IDLE;
    end else if (state_q == IDLE) begin
      if (md_accept) begin
        state_q <= BUSY;
        cnt_q   <= '0;
      end
    end else begin
      cnt_q <= cnt_q + SH'(1);
      if (md_done) state_q <= IDLE;
    end
  end

  // Operand capture at accept (p1), then iteration while BUSY
  always_ff @(posedge clk) begin
    if (md_accept) begin
      md_op_p1    <= bus.md_op_i;
      neg_p1      <= (bus.md_op_i[2] & bus.md_op_i[1]) ? a_neg : (a_neg ^ b_neg);
      spec_p1     <= div0 | ovf;
      spec_res_p1 <= spec_res;
      hi_p1       <= '0;
      lo_p1       <= bus.md_op_i[2] ? a_mag : b_mag;
      opb_p1      <= bus.md_op_i[2] ? b_mag : a_mag;
      store_p1    <= fwd_b;
      pc_p1       <= bus.pc_i;
      pcd_p1      <= pc_dest;
      rd_p1       <= rd_add;
      ctrl_p1     <= {bus.regwrite_i, bus.mem_rd_i, bus.mem_wr_i, bus.mem_op_i, bus.sel_to_reg_i};
    end else if (state_q == BUSY) begin
      hi_p1 <= md_op_p1[2] ? div_hi_n : mul_hi_n;
      lo_p1 <= md_op_p1[2] ? div_lo_n : mul_lo_n;
    end
  end
`else
  logic unused_md;
  assign unused_md = ^{bus.md_req_i, bus.md_op_i};
  assign in_ready  = 1'b1;
  assign alu_load  = accept;
`endif

  // EX/MEM boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid_o  <= 1'b0;
      bus.result_o     <= '0;
      bus.store_data_o <= '0;
      bus.pc_o         <= '0;
      bus.pc_dest_o    <= '0;
      bus.zero_o       <= 1'b0;
      bus.rd_add_o     <= '0;
      bus.regwrite_o   <= 1'b0;
      bus.mem_rd_o     <= 1'b0;
      bus.mem_wr_o     <= 1'b0;
      bus.mem_op_o     <= '0;
      bus.sel_to_reg_o <= '0;
    end else begin
      bus.out_valid_o <= 1'b0;
      bus.regwrite_o  <= 1'b0;
      bus.mem_rd_o    <= 1'b0;
      bus.mem_wr_o    <= 1'b0;
      if (alu_load) begin
        bus.out_valid_o  <= 1'b1;
        bus.result_o     <= alu_res;
        bus.zero_o       <= (alu_res == '0);
        bus.store_data_o <= fwd_b;
        bus.pc_o         <= bus.pc_i;
        bus.pc_dest_o    <= pc_dest;
        bus.rd_add_o     <= rd_add;
        bus.regwrite_o   <= bus.regwrite_i;
        bus.mem_rd_o     <= bus.mem_rd_i;
        bus.mem_wr_o     <= bus.mem_wr_i;
        bus.mem_op_o     <= bus.mem_op_i;
        bus.sel_to_reg_o <= bus.sel_to_reg_i;
      end
`ifdef EX_MD_EN
      else if (md_done) begin
        bus.out_valid_o  <= 1'b1;
        bus.result_o     <= md_res;
        bus.zero_o       <= (md_res == '0);
        bus.store_data_o <= store_p1;
        bus.pc_o         <= pc_p1;
        bus.pc_dest_o    <= pcd_p1;
        bus.rd_add_o     <= rd_p1;
        {bus.regwrite_o, bus.mem_rd_o, bus.mem_wr_o, bus.mem_op_o, bus.sel_to_reg_o} <= ctrl_p1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_ex_stage_md.sv
// Scoreboard bench for ex_stage_md; multiply/divide scenarios run when EX_MD_EN is defined.
module tb_ex_stage_md;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam logic [31:0] MEMF = 32'd7;
  localparam logic [31:0] WBF  = 32'h0000_1234;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_stage_md_if #(.DATA_WIDTH(DW), .REG_ADDR_W(RW)) bus ();
  ex_stage_md #(.DATA_WIDTH(DW), .REG_ADDR_W(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    string       tag;
    logic [31:0] res, pcd, st, pc;
    logic [4:0]  rd;
    logic [8:0]  ctrl;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] p;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: p = {32'b0, a} * {32'b0, b};
      3'd1: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      3'd2: p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
      3'd3: p = {32'b0, a} * {32'b0, b};
      default: p = '0;
    endcase
    if (op == 3'd0) return p[31:0];
    if (!op[2]) return p[63:32];
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      3'd4:    return sa / sb;
      3'd5:    return a / b;
      3'd6:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic drive(input logic md, input logic [3:0] op, input logic [2:0] mop,
                       input logic [1:0] fa, input logic [1:0] fb, input logic sa, input logic sb,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] rd, input logic [8:0] ctrl);
    bus.in_valid_i = 1'b1;
    bus.md_req_i = md;  bus.alu_op_i = op;  bus.md_op_i = mop;
    bus.fwd_a_i = fa;   bus.fwd_b_i = fb;   bus.sel_a_i = sa;  bus.sel_b_i = sb;
    bus.rs1_data_i = rs1;  bus.rs2_data_i = rs2;  bus.imm_i = imm;  bus.pc_i = pc;
    bus.rd_add_i = rd;
    {bus.regwrite_i, bus.mem_rd_i, bus.mem_wr_i, bus.mem_op_i, bus.sel_to_reg_i} = ctrl;
  endtask

  // Drives one instruction for one cycle and queues what EX/MEM must show for it
  task automatic issue(input string tag, input logic md, input logic [3:0] op, input logic [2:0] mop,
                       input logic [1:0] fa, input logic [1:0] fb, input logic sa, input logic sb,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic fixed, input logic [31:0] fixed_res);
    exp_t e;
    logic [31:0] va, vb, a, b;
    va = (fa == 2'b01) ? MEMF : (fa == 2'b10) ? WBF : rs1;
    vb = (fb == 2'b01) ? MEMF : (fb == 2'b10) ? WBF : rs2;
    a  = sa ? pc : va;
    b  = sb ? imm : vb;
    e.tag  = tag;
`ifdef EX_MD_EN
    e.res  = fixed ? fixed_res : (md ? md_model(mop, a, b) : alu_model(op, a, b));
`else
    e.res  = fixed ? fixed_res : alu_model(op, a, b);
`endif
    e.pcd  = pc + imm;
    e.st   = vb;
    e.pc   = pc;
    e.rd   = 5'($urandom);
    e.ctrl = 9'($urandom);
    drive(md, op, mop, fa, fb, sa, sb, rs1, rs2, imm, pc, e.rd, e.ctrl);
    sb_q.push_back(e);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.in_ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (bus.out_valid_o) begin
      if (sb_q.size() == 0) check_val("unexpected_valid", 64'd1, 64'd0);
      else begin
        mon_e = sb_q.pop_front();
        check_val({mon_e.tag, "_res"}, bus.result_o, mon_e.res);
        check_val({mon_e.tag, "_zero"}, bus.zero_o, (mon_e.res == 32'd0));
        check_val({mon_e.tag, "_pcdest"}, bus.pc_dest_o, mon_e.pcd);
        check_val({mon_e.tag, "_store"}, bus.store_data_o, mon_e.st);
        check_val({mon_e.tag, "_pc"}, bus.pc_o, mon_e.pc);
        check_val({mon_e.tag, "_rd"}, bus.rd_add_o, mon_e.rd);
        check_val({mon_e.tag, "_ctrl"}, {bus.regwrite_o, bus.mem_rd_o, bus.mem_wr_o,
                  bus.mem_op_o, bus.sel_to_reg_o}, mon_e.ctrl);
      end
    end else begin
      check_val("bubble_ctrl", {bus.regwrite_o, bus.mem_rd_o, bus.mem_wr_o}, 3'b000);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cyc;
    logic [31:0] ra, rb;
    logic [2:0]  mop;
    drive(1'b0, 4'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    bus.in_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.mem_fwd_data_i = MEMF;
    bus.wb_fwd_data_i = WBF;

    repeat (3) @(negedge clk);
    check_val("rst_out_valid", bus.out_valid_o, 1'b0);
    check_val("rst_result", bus.result_o, 32'd0);
    check_val("rst_pc_dest", bus.pc_dest_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", bus.in_ready_o, 1'b1);

    issue("add_fwd", 1'b0, 4'd0, 3'd0, 2'b01, 2'b00, 1'b0, 1'b0, 32'd5, 32'd3, 32'd0, 32'h100, 1'b1, 32'd10);
    wait_ready(n);
    check_val("alu_no_stall", n, 0);
    issue("sub_zero", 1'b0, 4'd1, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd9, 32'd9, 32'd4, 32'h200, 1'b1, 32'd0);
    issue("sra_max", 1'b0, 4'd7, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF);
    issue("slt_neg", 1'b0, 4'd3, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 32'd1);
    issue("sltu_neg", 1'b0, 4'd4, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 32'd0);
    issue("auipc_like", 1'b0, 4'd0, 3'd0, 2'b11, 2'b10, 1'b1, 1'b1, 32'd1, 32'd2, 32'h0000_1000, 32'h0000_0040, 1'b1, 32'h0000_1040);
    for (int i = 0; i < 16; i++)
      issue("alu_rand", 1'b0, 4'(i), 3'd0, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom, $urandom, 1'b0, 32'd0);

    drive(1'b0, 4'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd3, 9'h1FF);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    check_val("flush_same_cycle", bus.out_valid_o, 1'b0);

`ifdef EX_MD_EN
    issue("mulhu", 1'b1, 4'd0, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 1'b1, 32'h0000_0002);
    wait_ready(n);
    check_val("mulhu_busy", n, 32);
    @(negedge clk);
    check_val("mulhu_pulse", bus.out_valid_o, 1'b0);
    issue("mul", 1'b1, 4'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFD);
    wait_ready(n);
    check_val("mul_busy", n, 32);
    issue("div_by0", 1'b1, 4'd0, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF);
    wait_ready(n);
    check_val("div_by0_busy", n, 1);
    issue("rem_by0", 1'b1, 4'd0, 3'd6, 2'b00, 2'b00, 1'b0, 1'b0, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1, 32'd7);
    wait_ready(n);
    check_val("rem_by0_busy", n, 1);
    issue("div_neg", 1'b1, 4'd0, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFD);
    wait_ready(n);
    issue("rem_neg", 1'b1, 4'd0, 3'd6, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF);
    wait_ready(n);
    check_val("rem_neg_busy", n, 32);
    issue("div_ovf", 1'b1, 4'd0, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 32'h8000_0000);
    wait_ready(n);
    check_val("div_ovf_busy", n, 1);
    issue("rem_ovf", 1'b1, 4'd0, 3'd6, 2'b00, 2'b00, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 32'd0);
    wait_ready(n);
    check_val("rem_ovf_busy", n, 1);
    for (int i = 0; i < 8; i++) begin
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      mop = 3'(i);
      issue("md_rand", 1'b1, 4'd0, mop, 2'($urandom_range(0, 2)), 2'b00, 1'b0, 1'b0,
            ra, rb, 32'd0, 32'd0, 1'b0, 32'd0);
      wait_ready(n);
      check_val("md_rand_busy", n, 32);
    end

    drive(1'b1, 4'd0, 3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 32'd1000, 32'd7, 32'd0, 32'd0, 5'd9, 9'h1FF);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check_val("flush_busy_ready", bus.in_ready_o, 1'b1);
    check_val("flush_busy_valid", bus.out_valid_o, 1'b0);
    check_val("flush_busy_regwrite", bus.regwrite_o, 1'b0);
    repeat (30) @(negedge clk);
    issue("add_after_flush", 1'b0, 4'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd20, 32'd22, 32'd0, 32'd0, 1'b1, 32'd42);

    drive(1'b1, 4'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 5'd2, 9'h1FF);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_valid", bus.out_valid_o, 1'b0);
    check_val("rst_mid_result", bus.result_o, 32'd0);
    check_val("rst_mid_regwrite", bus.regwrite_o, 1'b0);
    check_val("rst_mid_pc_dest", bus.pc_dest_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_release_ready", bus.in_ready_o, 1'b1);
    check_val("rst_release_valid", bus.out_valid_o, 1'b0);
    repeat (35) @(negedge clk);
`else
    issue("md_ignored", 1'b1, 4'd0, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 1'b1, 32'd2);
    wait_ready(n);
    check_val("md_ignored_stall", n, 0);
    check_val("ready_tied", bus.in_ready_o, 1'b1);
`endif

    issue("add_final", 1'b0, 4'd0, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 32'd8);
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    @(negedge clk);
    check_val("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
